rf_writeback_queue: RTL

- Buffers register writeback requests from two producers: the ALU path and the load/memory path.
- Drains them, one per cycle and in order, into the register file write port (rd, rd_din, write_enable).
- Gives the decode stage a pending-write check on rs1/rs2 for hazard stalls.
- Sits between the execute/memory stages and the register file write side.

---
 rtl/rf_writeback_queue_if.sv | 39 +++
 rtl/rf_writeback_queue.sv | 101 ++++++++++
 2 files changed

// File: rtl/rf_writeback_queue_if.sv
// Writeback request, register-file write and hazard-check signals of rf_writeback_queue.
// The queue itself connects through the slave modport, and the driving side through the master modport.
interface rf_writeback_queue_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [4:0]        mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [DATA_W-1:0] rf_din;
    logic [4:0]        chk_rs1;
    logic [4:0]        chk_rs2;
    logic              rs1_pending;
    logic              rs2_pending;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    // valid/ready: a request transfers at the clk edge where valid && ready are both high;
    // ready never depends on valid of the same producer, and the memory path wins a tie.
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs1, chk_rs2,
        output alu_ready, mem_ready, rf_we, rf_rd, rf_din, rs1_pending, rs2_pending,
        output count, full, empty
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs1, chk_rs2,
        input  alu_ready, mem_ready, rf_we, rf_rd, rf_din, rs1_pending, rs2_pending,
        input  count, full, empty
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order register writeback queue draining one entry per cycle into the register file.
// Optional macro RF_WB_BYPASS_EN: a request arriving while empty is written the same cycle.
module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    rf_writeback_queue_if.slave wb
);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]        rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              full, empty;
    logic              accept, push, pop, bypass;
    logic [4:0]        in_rd;
    logic [DATA_W-1:0] in_data;
    logic [PW-1:0]     offset;
    logic              p1, p2;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign wb.count     = count_q;
    assign wb.full      = full;
    assign wb.empty     = empty;
    assign wb.mem_ready = !full;
    assign wb.alu_ready = !full && !wb.mem_valid;

    assign in_rd   = wb.mem_valid ? wb.mem_rd   : wb.alu_rd;
    assign in_data = wb.mem_valid ? wb.mem_data : wb.alu_data;
    assign accept  = !full && (wb.mem_valid || wb.alu_valid);
    assign pop     = !empty;

`ifdef RF_WB_BYPASS_EN
    assign bypass = accept && (in_rd != 5'd0) && empty;
`else
    assign bypass = 1'b0;
`endif
    // rd==0 requests are acknowledged but never occupy an entry.
    assign push = accept && (in_rd != 5'd0) && !bypass;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            rd_q[tail_q]   <= in_rd;
            data_q[tail_q] <= in_data;
        end
    end

    always_comb begin
        wb.rf_we  = 1'b0;
        wb.rf_rd  = 5'd0;
        wb.rf_din = '0;
        if (!empty) begin
            wb.rf_we  = 1'b1;
            wb.rf_rd  = rd_q[head_q];
            wb.rf_din = data_q[head_q];
        end else if (bypass) begin
            wb.rf_we  = 1'b1;
            wb.rf_rd  = in_rd;
            wb.rf_din = in_data;
        end
    end

    // An entry is live when its distance from head is below count; head included.
    always_comb begin
        p1     = 1'b0;
        p2     = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head_q;
            if (CNT_W'(offset) < count_q) begin
                if (rd_q[i] == wb.chk_rs1) p1 = 1'b1;
                if (rd_q[i] == wb.chk_rs2) p2 = 1'b1;
            end
        end
        wb.rs1_pending = p1 && (wb.chk_rs1 != 5'd0);
        wb.rs2_pending = p2 && (wb.chk_rs2 != 5'd0);
    end
endmodule
